// File: rtl/writeback_regfile.sv
// Writeback stage and 16-entry architectural register file. Plain results commit directly.
// Loads and stores run a single-outstanding memory handshake. Two read ports are forwarded.
module writeback_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              mem_r,
  input  logic              mem_w,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              plain_acc, load_ack, wr_en;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] store_data;

  assign plain_acc = in_valid && (state_q == StIdle) && !mem_r && !mem_w;
  assign load_ack  = (state_q == StLoad) && mem_ack;

  // At most one of plain_acc / load_ack can be true, so a single commit port suffices.
  always_comb begin
    commit_addr = write_addr;
    commit_data = alu_out;
    if (load_ack) begin
      commit_addr = dest_q;
      commit_data = mem_rdata;
    end
  end

  assign wr_en = (plain_acc || load_ack) && (commit_addr != '0);

  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a,
                                            input logic              en,
                                            input logic [ADDR_W-1:0] ca,
                                            input logic [DATA_W-1:0] cd,
                                            input logic [DATA_W-1:0] rv);
    if (a == '0)            return '0;
    else if (en && ca == a) return cd;
    else                    return rv;
  endfunction

  assign rd_data_a  = fwd(rd_addr_a, wr_en, commit_addr, commit_data, regs_q[rd_addr_a]);
  assign rd_data_b  = fwd(rd_addr_b, wr_en, commit_addr, commit_data, regs_q[rd_addr_b]);
  assign store_data = fwd(write_addr, wr_en, commit_addr, commit_data, regs_q[write_addr]);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[commit_addr] = commit_data;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    wb_valid_d  = wr_en;
    wb_addr_d   = wr_en ? commit_addr : wb_addr_q;
    wb_data_d   = wr_en ? commit_data : wb_data_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && mem_r) begin
          state_d    = StLoad;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = alu_out;
          dest_d     = write_addr;
        end else if (in_valid && mem_w) begin
          state_d     = StStore;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = alu_out;
          mem_wdata_d = store_data;
        end
      end
      StLoad, StStore: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      regs_q      <= regs_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the stage.
module tb_writeback_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] alu_out;
  logic [3:0] write_addr;
  logic       mem_r, mem_w;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       wb_valid;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .write_addr(write_addr),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: architectural state plus an optional outstanding memory transaction.
  logic [7:0] m_regs [16];
  logic       m_busy, m_store;
  logic [7:0] m_addr, m_wdata;
  logic [3:0] m_dest;
  logic       m_wbv;
  logic [3:0] m_wba;
  logic [7:0] m_wbd;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_busy = 0; m_store = 0; m_addr = 0; m_wdata = 0; m_dest = 0;
    m_wbv = 0; m_wba = 0; m_wbd = 0;
  endtask

  initial model_reset();

  // Compare process: inputs change at negedge, outputs checked 2 time units later.
  always begin
    logic       c_en;
    logic [3:0] c_a;
    logic [7:0] c_d, e_a, e_b, st_d;
    @(negedge clk);
    #2;
    if (rst) model_reset();
    // The value being committed at the coming edge, if any, is what reads must see now.
    c_en = 0; c_a = 0; c_d = 0;
    if (!m_busy && in_valid && !mem_r && !mem_w) begin
      c_en = 1; c_a = write_addr; c_d = alu_out;
    end else if (m_busy && !m_store && mem_ack) begin
      c_en = 1; c_a = m_dest; c_d = mem_rdata;
    end
    if (c_a == 0) c_en = 0;
    e_a  = (rd_addr_a == 0) ? 8'h00 : (c_en && c_a == rd_addr_a) ? c_d : m_regs[rd_addr_a];
    e_b  = (rd_addr_b == 0) ? 8'h00 : (c_en && c_a == rd_addr_b) ? c_d : m_regs[rd_addr_b];
    st_d = (write_addr == 0) ? 8'h00 : m_regs[write_addr];
    chk("in_ready", in_ready, !m_busy);
    chk("mem_req", mem_req, m_busy);
    chk("mem_we", mem_we, m_busy && m_store);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("wb_valid", wb_valid, m_wbv);
    chk("wb_addr", wb_addr, m_wba);
    chk("wb_data", wb_data, m_wbd);
    chk("rd_data_a", rd_data_a, e_a);
    chk("rd_data_b", rd_data_b, e_b);
    if (!rst) begin
      m_wbv = c_en;
      if (c_en) begin
        m_regs[c_a] = c_d; m_wba = c_a; m_wbd = c_d;
      end
      if (!m_busy && in_valid && (mem_r || mem_w)) begin
        m_busy  = 1;
        m_store = !mem_r;
        m_addr  = alu_out;
        if (mem_r) m_dest = write_addr;
        else       m_wdata = st_d;
      end else if (m_busy && mem_ack) begin
        m_busy = 0; m_store = 0;
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; mem_r = 0; mem_w = 0; mem_ack = 0;
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic plain(input logic [3:0] a, input logic [7:0] d);
    in_valid = 1; write_addr = a; alu_out = d;
  endtask

  initial begin
    rst = 1; idle_inputs();
    alu_out = 0; write_addr = 0; mem_rdata = 0; rd_addr_a = 0; rd_addr_b = 0;
    step(); step();
    rd_addr_a = 3; #3;
    chk("lit reset mem_req", mem_req, 0);
    chk("lit reset rd R3", rd_data_a, 8'h00);
    step(); rst = 0;

    step(); plain(3, 8'h5A); rd_addr_a = 3; #3;
    chk("lit fwd R3", rd_data_a, 8'h5A);
    step(); plain(4, 8'hA5); #3;
    chk("lit wb R3 valid", wb_valid, 1);
    chk("lit wb R3 data", {wb_addr, wb_data}, {4'd3, 8'h5A});
    step(); rd_addr_a = 3; rd_addr_b = 4; #3;
    chk("lit wb R4 data", {wb_valid, wb_addr, wb_data}, {1'b1, 4'd4, 8'hA5});
    chk("lit rd R3", rd_data_a, 8'h5A);
    chk("lit rd R4", rd_data_b, 8'hA5);
    step(); plain(7, 8'h11); rd_addr_a = 7; #3;
    chk("lit fwd R7", rd_data_a, 8'h11);
    step(); plain(0, 8'hFF); rd_addr_a = 0; #3;
    chk("lit fwd R0", rd_data_a, 8'h00);
    step(); #3;
    chk("lit R0 no wb", wb_valid, 0);

    step(); in_valid = 1; mem_r = 1; alu_out = 8'h40; write_addr = 5; rd_addr_a = 5;
    for (int i = 0; i < 3; i++) begin
      step(); #3;
      chk("lit load req", {mem_req, mem_we, in_ready, mem_addr}, {3'b100, 8'h40});
    end
    step(); mem_ack = 1; mem_rdata = 8'hC3; #3;
    chk("lit load fwd", rd_data_a, 8'hC3);
    step(); #3;
    chk("lit load wb", {wb_valid, wb_addr, wb_data}, {1'b1, 4'd5, 8'hC3});
    chk("lit load idle", {in_ready, mem_req}, 2'b10);

    step(); plain(2, 8'h9E);
    step(); in_valid = 1; mem_w = 1; alu_out = 8'h80; write_addr = 2;
    step(); #3;
    chk("lit store req", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h80, 8'h9E});
    step(); mem_ack = 1;
    step(); #3;
    chk("lit store done", {in_ready, wb_valid, mem_req}, 3'b100);

    step(); in_valid = 1; mem_r = 1; mem_w = 1; alu_out = 8'h33; write_addr = 6;
    step(); #3;
    chk("lit both flags", {mem_req, mem_we}, 2'b10);
    step(); mem_ack = 1; mem_rdata = 8'h44;
    step();
    step(); mem_ack = 1; mem_rdata = 8'hEE; rd_addr_a = 6; #3;
    chk("lit spurious ack rd", rd_data_a, 8'h44);
    step(); #3;
    chk("lit spurious ack wb", {wb_valid, in_ready}, 2'b01);

    step(); in_valid = 1; mem_r = 1; alu_out = 8'h10; write_addr = 9;
    step(); #3;
    chk("lit pre-reset req", mem_req, 1);
    step(); rst = 1; rd_addr_a = 3; #3;
    chk("lit reset mid load", {mem_req, rd_data_a}, {1'b0, 8'h00});
    step(); rst = 0; mem_ack = 1; mem_rdata = 8'h77; rd_addr_a = 9; #3;
    chk("lit late ack rd", rd_data_a, 8'h00);
    step(); #3;
    chk("lit late ack wb", {wb_valid, rd_data_a}, {1'b0, 8'h00});

    for (int i = 0; i < 3000; i++) begin
      step();
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = $urandom_range(0, 1);
      mem_r      = ($urandom_range(0, 4) == 0);
      mem_w      = ($urandom_range(0, 4) == 0);
      mem_ack    = ($urandom_range(0, 2) == 0);
      alu_out    = 8'($urandom);
      mem_rdata  = 8'($urandom);
      write_addr = 4'($urandom);
      rd_addr_a  = 4'($urandom);
      rd_addr_b  = ($urandom_range(0, 1) == 0) ? write_addr : 4'($urandom);
    end
    step(); rst = 0;
    step();
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage plus architectural register file, directly downstream of the ALU.
- Consumes the ALU result, destination address and memory-read/memory-write flags.
- Commits the result to a 16 x 8 register file, or performs a single-outstanding load/store handshake with data memory.
- Provides two forwarded combinational read ports that feed the ALU A/B operands.

Parameters:
DATA_W, 8, width of ALU result, registers and memory data
ADDR_W, 4, register address width (2**ADDR_W registers)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  ALU result presented this cycle
in_ready  output  1  stage can accept; high only in IDLE
alu_out  input  DATA_W  ALU result (register data or memory address)
write_addr  input  ADDR_W  destination register (load/plain); store-data source register (store)
mem_r  input  1  result is a load address
mem_w  input  1  result is a store address
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = store, 0 = load; valid while mem_req
mem_addr  output  DATA_W  latched alu_out
mem_wdata  output  DATA_W  store data latched at acceptance
mem_ack  input  1  memory completes current request this cycle
mem_rdata  input  DATA_W  load data, valid with mem_ack
rd_addr_a  input  ADDR_W  read port A address
rd_data_a  output  DATA_W  read port A data (combinational)
rd_addr_b  input  ADDR_W  read port B address
rd_data_b  output  DATA_W  read port B data (combinational)
wb_valid  output  1  one-cycle pulse: a register was written at the previous edge
wb_addr  output  ADDR_W  register written
wb_data  output  DATA_W  value written

Behaviour:
- Reset (async, rst=1):
  - All registers 0.
  - State IDLE.
  - mem_req, mem_we, wb_valid = 0.
  - mem_addr, mem_wdata, wb_addr, wb_data = 0.
  - Any in-flight transaction is abandoned with no register write. A mem_ack arriving after reset is ignored.
- Accept: in_valid && in_ready at a rising edge. in_ready = (state == IDLE).
- FSM states: IDLE, LOAD, STORE.
- IDLE, accepted, mem_r=0, mem_w=0 (plain op):
  - regs[write_addr] <= alu_out at that edge.
  - Next cycle: wb_valid=1, wb_addr=write_addr, wb_data=alu_out.
  - Remain in IDLE. Back-to-back plain ops are accepted every cycle.
- IDLE, accepted, mem_r=1 (mem_w ignored; load has priority):
  - Latch mem_addr=alu_out and dest=write_addr. Go to LOAD.
- IDLE, accepted, mem_r=0, mem_w=1:
  - Latch mem_addr=alu_out and mem_wdata = forwarded read of write_addr. Go to STORE.
- LOAD:
  - mem_req=1, mem_we=0, mem_addr held.
  - On mem_ack: regs[dest] <= mem_rdata, wb_valid pulse next cycle, go to IDLE.
- STORE:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata held.
  - On mem_ack: go to IDLE. No register write, no wb_valid.
- Request stability: mem_req rises the cycle after acceptance. mem_addr, mem_we and mem_wdata stay constant until the ack edge. mem_req=0 in IDLE. There is no timeout; the stage waits indefinitely for mem_ack.
- Earliest re-accept: a new input is accepted at the earliest in the cycle after the ack edge. Minimum load/store occupancy is 2 cycles.
- mem_ack in IDLE is ignored.
- Register 0 is hardwired to 0:
  - Writes to address 0 are discarded and produce no wb_valid pulse.
  - Reads of address 0 return 0 regardless of forwarding.
- Read forwarding, per port, priority order:
  1. Address 0 returns 0.
  2. In IDLE with an accepting plain op whose write_addr == rd_addr: return alu_out.
  3. In LOAD with mem_ack=1 and dest == rd_addr: return mem_rdata.
  4. Otherwise return the register array.
- Store data uses the same forwarding, so a store immediately after a plain op that writes the source register stores the new value.
- Widths: no arithmetic. All data is DATA_W bits, passed unmodified.
- Simultaneous events: acceptance in the cycle of an ack is impossible, since in_ready=0 outside IDLE. When mem_ack and rst coincide, rst wins.

Test Plan:
- Reset, then plain writes R3=0x5A and R4=0xA5 on consecutive cycles. Next cycles show wb_valid with (3,0x5A) then (4,0xA5). rd_addr_a=3 → 0x5A, rd_addr_b=4 → 0xA5.
- Forwarding: while accepting a write R7=0x11, rd_addr_a=7 → 0x11 in the same cycle. Write R0=0xFF → no wb_valid, and rd 0 → 0x00.
- Load: accept mem_r=1, alu_out=0x40, write_addr=5. mem_req=1, mem_we=0, mem_addr=0x40. Hold mem_ack=0 for 3 cycles (in_ready=0, outputs stable). Ack with mem_rdata=0xC3 → R5=0xC3, wb_valid pulse, then IDLE.
- Store: R2=0x9E written, then immediately accept mem_w=1, alu_out=0x80, write_addr=2 → mem_we=1, mem_addr=0x80, mem_wdata=0x9E. On ack → no wb_valid, in_ready=1 next cycle.
- mem_r=1 and mem_w=1 together → load behaviour (mem_we=0). Spurious mem_ack in IDLE → no state or register change.
- Assert rst while in LOAD with mem_req=1 → mem_req=0 immediately and all registers read 0. A later mem_ack with 0x77 writes nothing.
